// File: rtl/time_digit_converter_if.sv
// Request/result bundle between the countdown counter (master) and the
// seconds-to-MM:SS digit converter (slave).
interface time_digit_converter_if #(
    parameter int CNT_W      = 12,
    parameter int MIN_DIGITS = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CNT_W-1:0]        sec_count;
    logic                    out_valid;
    logic [4*MIN_DIGITS-1:0] min_bcd;
    logic [3:0]              sec_tens;
    logic [3:0]              sec_ones;
    logic                    ovf;

    modport master (
        output in_valid, sec_count,
        input  in_ready, out_valid, min_bcd, sec_tens, sec_ones, ovf
    );

    modport slave (
        input  in_valid, sec_count,
        output in_ready, out_valid, min_bcd, sec_tens, sec_ones, ovf
    );
endinterface

// File: rtl/time_digit_converter.sv
// Sequential seconds-to-MM:SS converter: restoring divide by 60, then double-dabble.
// Optional build macro TIME_DIGIT_ZERO_BLANK_EN blanks leading zero minute digits (4'hF).
module time_digit_converter #(
    parameter int CNT_W      = 12,
    parameter int MIN_DIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    time_digit_converter_if.slave  bus
);

    // Decimal digits of 2^CNT_W (floor(CNT_W*log10(2))+1) always cover 2^CNT_W-1.
    localparam int BCD_DIGITS = (CNT_W * 30103) / 100000 + 1;
    localparam int NDIG       = (BCD_DIGITS > MIN_DIGITS) ? BCD_DIGITS : MIN_DIGITS;
    localparam int CW         = $clog2(CNT_W + 2);

    typedef enum logic [1:0] {IDLE, DIV, BCD, DONE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [CNT_W-1:0]        dvd_q;
    logic [5:0]              rem_q;
    logic [4*NDIG-1:0]       bcd_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [4*MIN_DIGITS-1:0] min_q;
    logic [3:0]              tens_q;
    logic [3:0]              ones_q;
    logic                    ovf_q;

    logic [6:0]              trial;
    logic [5:0]              rem_d;
    logic [CNT_W-1:0]        dvd_d;
    logic [4*NDIG-1:0]       bcd_adj;
    logic [4*NDIG-1:0]       bcd_d;
    logic                    ovf_d;
    logic [4*MIN_DIGITS-1:0] min_d;
    logic [3:0]              tens_d;
    logic [3:0]              ones_d;
`ifdef TIME_DIGIT_ZERO_BLANK_EN
    logic                    leading;
`endif

    // One restoring step: the shifted-in quotient bit replaces the consumed dividend bit.
    always_comb begin
        trial = {rem_q, dvd_q[CNT_W-1]};
        if (trial >= 7'd60) begin
            rem_d = 6'(trial - 7'd60);
            dvd_d = {dvd_q[CNT_W-2:0], 1'b1};
        end else begin
            rem_d = trial[5:0];
            dvd_d = {dvd_q[CNT_W-2:0], 1'b0};
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[4*NDIG-2:0], dvd_q[CNT_W-1]};
    end

    // Final-cycle result formatting from the completed quotient digits and remainder.
    always_comb begin
        ovf_d = 1'b0;
        for (int i = MIN_DIGITS; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) ovf_d = 1'b1;
        end

        tens_d = 4'd0;
        for (int t = 1; t <= 5; t++) begin
            if (rem_q >= 6'(10 * t)) tens_d = 4'(t);
        end
        ones_d = 4'(rem_q - 6'(10 * tens_d));

        min_d = bcd_q[4*MIN_DIGITS-1:0];
`ifdef TIME_DIGIT_ZERO_BLANK_EN
        leading = 1'b1;
        for (int i = MIN_DIGITS - 1; i >= 1; i--) begin
            if (leading && bcd_q[4*i +: 4] == 4'd0) min_d[4*i +: 4] = 4'hF;
            else                                    leading = 1'b0;
        end
`endif

        if (ovf_d) begin
            min_d  = {MIN_DIGITS{4'h9}};
            tens_d = 4'd5;
            ones_d = 4'd9;
        end
    end

    // NOTE: datapath registers are reset along with the FSM so an aborted
    // conversion leaves nothing behind that could leak into a later result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            bcd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            min_q       <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.in_valid) begin
                        dvd_q       <= bus.sec_count;
                        rem_q       <= '0;
                        bcd_q       <= '0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        state_q     <= DIV;
                    end
                end
                DIV: begin
                    dvd_q <= dvd_d;
                    rem_q <= rem_d;
                    if (cnt_q == CW'(CNT_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= BCD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BCD: begin
                    // CNT_W shift cycles, then one cycle to saturate and register.
                    if (cnt_q == CW'(CNT_W)) begin
                        min_q       <= min_d;
                        tens_q      <= tens_d;
                        ones_q      <= ones_d;
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        bcd_q <= bcd_d;
                        dvd_q <= {dvd_q[CNT_W-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.min_bcd   = min_q;
    assign bus.sec_tens  = tens_q;
    assign bus.sec_ones  = ones_q;
    assign bus.ovf       = ovf_q;

endmodule
